// File: rtl/avalon_st_pkg.sv
// Shared types for the Avalon-ST packet transmitter.
package avalon_st_pkg;

  typedef enum logic {
    FILL_S = 1'b0,
    SEND_S = 1'b1
  } state_e;

endpackage : avalon_st_pkg

// File: rtl/avalon_st_pkt_tx_pkt_buf.sv
// Packet word store: one synchronous write port, one asynchronous read port.
module pkt_buf #(
  parameter int DWIDTH = 4,
  parameter int DEPTH  = 5,
  parameter int AW     = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; every word is written before the FSM lets it be read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : pkt_buf

// File: rtl/avalon_st_pkt_tx.sv
// Buffers one packet from a simple write port, then replays it as an Avalon-ST source.
module avalon_st_pkt_tx
  import avalon_st_pkg::*;
#(
  parameter int DWIDTH      = 4,
  parameter int MAX_PKT_LEN = 5
) (
  input  logic                           clk_i,
  input  logic                           srst_i,
  input  logic [DWIDTH-1:0]              wr_data_i,
  input  logic                           wr_valid_i,
  input  logic                           wr_last_i,
  output logic                           wr_ready_o,
  input  logic                           src_ready_i,
  output logic [DWIDTH-1:0]              src_data_o,
  output logic                           src_valid_o,
  output logic                           src_startofpacket_o,
  output logic                           src_endofpacket_o,
  output logic [$clog2(MAX_PKT_LEN):0]   pkt_len_o,
  output logic                           overflow_o
);

  localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam int LW = $clog2(MAX_PKT_LEN) + 1;

  state_e            state_q;
  logic [AW-1:0]     wr_cnt_q;
  logic [AW-1:0]     rd_cnt_q;
  logic [LW-1:0]     pkt_len_q;
  logic              overflow_q;
  logic [DWIDTH-1:0] rd_data;
  logic              wr_fire;
  logic              wr_at_max;
  logic              is_eop;

  assign wr_fire   = (state_q == FILL_S) && wr_valid_i;
  assign wr_at_max = (wr_cnt_q == AW'(MAX_PKT_LEN - 1));
  assign is_eop    = (LW'(rd_cnt_q) == pkt_len_q - LW'(1));

  pkt_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MAX_PKT_LEN),
    .AW     (AW)
  ) u_pkt_buf (
    .clk_i   (clk_i),
    .we_i    (wr_fire),
    .waddr_i (wr_cnt_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_cnt_q),
    .rdata_o (rd_data)
  );

  // NOTE: non-blocking assignments keep every register update order-independent.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= FILL_S;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      pkt_len_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case (state_q)
        FILL_S: begin
          if (wr_fire) begin
            wr_cnt_q <= wr_cnt_q + AW'(1);
            if (wr_last_i || wr_at_max) begin
              pkt_len_q  <= LW'(wr_cnt_q) + LW'(1);
              state_q    <= SEND_S;
              overflow_q <= !wr_last_i;
            end
          end
        end
        SEND_S: begin
          if (src_ready_i) begin
            if (is_eop) begin
              state_q  <= FILL_S;
              wr_cnt_q <= '0;
              rd_cnt_q <= '0;
            end else begin
              rd_cnt_q <= rd_cnt_q + AW'(1);
            end
          end
        end
        default: state_q <= FILL_S;
      endcase
    end
  end

  // Source signals are decoded from registered state, so they hold while stalled.
  assign wr_ready_o          = (state_q == FILL_S);
  assign src_valid_o         = (state_q == SEND_S);
  assign src_data_o          = src_valid_o ? rd_data : '0;
  assign src_startofpacket_o = src_valid_o && (rd_cnt_q == '0);
  assign src_endofpacket_o   = src_valid_o && is_eop;
  assign pkt_len_o           = pkt_len_q;
  assign overflow_o          = overflow_q;

endmodule : avalon_st_pkt_tx

// File: tb/tb_avalon_st_pkt_tx.sv
// Directed bench for avalon_st_pkt_tx with hand-computed expectations.
module tb_avalon_st_pkt_tx;

  logic       clk = 1'b0;
  logic       srst;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_last;
  logic       wr_ready;
  logic       src_ready;
  logic [3:0] src_data;
  logic       src_valid;
  logic       src_sop;
  logic       src_eop;
  logic [3:0] pkt_len;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  avalon_st_pkt_tx #(
    .DWIDTH      (4),
    .MAX_PKT_LEN (5)
  ) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .wr_data_i           (wr_data),
    .wr_valid_i          (wr_valid),
    .wr_last_i           (wr_last),
    .wr_ready_o          (wr_ready),
    .src_ready_i         (src_ready),
    .src_data_o          (src_data),
    .src_valid_o         (src_valid),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .pkt_len_o           (pkt_len),
    .overflow_o          (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one write for a single cycle, then release wr_valid_i.
  task automatic wr(input logic [3:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [3:0] d, input logic sop, input logic eop);
    check({tag, "_valid"}, 32'(src_valid), 32'd1);
    check({tag, "_data"},  32'(src_data),  32'(d));
    check({tag, "_sop"},   32'(src_sop),   32'(sop));
    check({tag, "_eop"},   32'(src_eop),   32'(eop));
  endtask

  initial begin
    srst = 1'b1; wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0; src_ready = 1'b1;
    tick();
    srst = 1'b0;
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_valid",    32'(src_valid), 32'd0);
    check("rst_data",     32'(src_data), 32'd0);
    check("rst_sop_eop",  32'({src_sop, src_eop}), 32'd0);
    check("rst_len",      32'(pkt_len), 32'd0);
    check("rst_ovf",      32'(overflow), 32'd0);

    // Packet 3,1,2 streamed back-to-back
    wr(4'd3, 1'b0);
    wr(4'd1, 1'b0);
    wr(4'd2, 1'b1);
    beat("p1b0", 4'd3, 1'b1, 1'b0);
    check("p1_len",      32'(pkt_len), 32'd3);
    check("p1_wr_ready", 32'(wr_ready), 32'd0);
    tick(); beat("p1b1", 4'd1, 1'b0, 1'b0);
    tick(); beat("p1b2", 4'd2, 1'b0, 1'b1);
    tick();
    check("p1_idle_valid", 32'(src_valid), 32'd0);
    check("p1_idle_ready", 32'(wr_ready), 32'd1);
    check("p1_idle_data",  32'(src_data), 32'd0);

    // Single-word packet
    wr(4'd7, 1'b1);
    beat("p2b0", 4'd7, 1'b1, 1'b1);
    check("p2_len", 32'(pkt_len), 32'd1);
    tick();
    check("p2_idle_valid", 32'(src_valid), 32'd0);
    check("p2_idle_ready", 32'(wr_ready), 32'd1);

    // Five words with no last: forced close and overflow pulse
    for (int i = 1; i <= 4; i++) wr(4'(i), 1'b0);
    check("p3_pre_ovf",   32'(overflow), 32'd0);
    check("p3_pre_ready", 32'(wr_ready), 32'd1);
    wr(4'd5, 1'b0);
    check("p3_ovf",  32'(overflow), 32'd1);
    check("p3_len",  32'(pkt_len), 32'd5);
    beat("p3b0", 4'd1, 1'b1, 1'b0);
    tick();
    check("p3_ovf_clear", 32'(overflow), 32'd0);
    beat("p3b1", 4'd2, 1'b0, 1'b0);
    tick(); beat("p3b2", 4'd3, 1'b0, 1'b0);
    tick(); beat("p3b3", 4'd4, 1'b0, 1'b0);
    tick(); beat("p3b4", 4'd5, 1'b0, 1'b1);
    check("p3_ovf_once", 32'(overflow), 32'd0);
    tick();
    check("p3_idle_valid", 32'(src_valid), 32'd0);

    // Packet 4,9 with three stall cycles per beat
    src_ready = 1'b0;
    wr(4'd4, 1'b0);
    wr(4'd9, 1'b1);
    beat("p4b0", 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); beat("p4b0_stall", 4'd4, 1'b1, 1'b0);
    end
    src_ready = 1'b1;
    tick();
    src_ready = 1'b0;
    beat("p4b1", 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); beat("p4b1_stall", 4'd9, 1'b0, 1'b1);
    end
    src_ready = 1'b1;
    tick();
    check("p4_idle_valid", 32'(src_valid), 32'd0);
    check("p4_idle_ready", 32'(wr_ready), 32'd1);

    // Reset in the middle of a 4-word packet, then a fresh packet
    wr(4'd1, 1'b0);
    wr(4'd2, 1'b0);
    wr(4'd3, 1'b0);
    wr(4'd4, 1'b1);
    beat("p5b0", 4'd1, 1'b1, 1'b0);
    tick();
    beat("p5b1", 4'd2, 1'b0, 1'b0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("p5_rst_valid", 32'(src_valid), 32'd0);
    check("p5_rst_eop",   32'(src_eop), 32'd0);
    check("p5_rst_ready", 32'(wr_ready), 32'd1);
    check("p5_rst_len",   32'(pkt_len), 32'd0);
    wr(4'd6, 1'b0);
    wr(4'd8, 1'b1);
    beat("p6b0", 4'd6, 1'b1, 1'b0);
    check("p6_len", 32'(pkt_len), 32'd2);
    tick(); beat("p6b1", 4'd8, 1'b0, 1'b1);
    tick();
    check("p6_idle_valid", 32'(src_valid), 32'd0);

    // Writes presented during SEND_S must be ignored
    src_ready = 1'b0;
    wr(4'd1, 1'b0);
    wr(4'd2, 1'b1);
    wr_valid = 1'b1; wr_data = 4'hF; wr_last = 1'b1;
    tick(); beat("p7b0_hold", 4'd1, 1'b1, 1'b0);
    check("p7_wr_ready", 32'(wr_ready), 32'd0);
    tick(); beat("p7b0_hold2", 4'd1, 1'b1, 1'b0);
    src_ready = 1'b1;
    tick(); beat("p7b1", 4'd2, 1'b0, 1'b1);
    check("p7_len", 32'(pkt_len), 32'd2);
    wr_valid = 1'b0; wr_last = 1'b0;
    tick();
    check("p7_idle_valid", 32'(src_valid), 32'd0);
    wr(4'hA, 1'b0);
    wr(4'hB, 1'b1);
    beat("p8b0", 4'hA, 1'b1, 1'b0);
    check("p8_len", 32'(pkt_len), 32'd2);
    tick(); beat("p8b1", 4'hB, 1'b0, 1'b1);
    tick();
    check("p8_idle_valid", 32'(src_valid), 32'd0);
    check("p8_idle_ready", 32'(wr_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_avalon_st_pkt_tx

// File: doc/avalon_st_pkt_tx.md
AVALON_ST_PKT_TX -- requirements
Module: avalon_st_pkt_tx

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 4, setting the data word width in bits.
REQ-002 The block SHALL have parameter MAX_PKT_LEN, default 5, setting the maximum number of words per packet.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port srst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_data_i, input, DWIDTH bits: word to load into the packet buffer.
REQ-006 The block SHALL have port wr_valid_i, input, 1 bit: wr_data_i is valid.
REQ-007 The block SHALL have port wr_last_i, input, 1 bit: current write is the last word of the packet.
REQ-008 The block SHALL have port wr_ready_o, output, 1 bit: the buffer accepts writes.
REQ-009 The block SHALL have port src_ready_i, input, 1 bit: Avalon-ST downstream ready, readyLatency 0.
REQ-010 The block SHALL have port src_data_o, output, DWIDTH bits: Avalon-ST data.
REQ-011 The block SHALL have port src_valid_o, output, 1 bit: Avalon-ST valid.
REQ-012 The block SHALL have port src_startofpacket_o, output, 1 bit: first beat of the packet.
REQ-013 The block SHALL have port src_endofpacket_o, output, 1 bit: last beat of the packet.
REQ-014 The block SHALL have port pkt_len_o, output, $clog2(MAX_PKT_LEN)+1 bits: word count of the stored/transmitting packet.
REQ-015 The block SHALL have port overflow_o, output, 1 bit: one-cycle pulse when a packet is force-closed at MAX_PKT_LEN.

Function
REQ-016 The block SHALL implement a two-state FSM with states FILL_S and SEND_S; srst_i forces FILL_S.
REQ-017 In FILL_S, wr_ready_o SHALL be 1; in SEND_S, it SHALL be 0 (decoded from state only, with no dependence on wr_valid_i).
REQ-018 A write SHALL be accepted when wr_valid_i && wr_ready_o: word stored at index wr_cnt, wr_cnt incremented; wr_valid_i while wr_ready_o=0 is ignored.
REQ-019 An accepted write with wr_last_i=1 SHALL close the packet: pkt_len_o <= wr_cnt+1, FSM -> SEND_S next cycle.
REQ-020 An accepted write at wr_cnt==MAX_PKT_LEN-1 with wr_last_i=0 SHALL close the packet identically and pulse overflow_o for exactly one cycle (the cycle after the write).
REQ-021 Latency: last write accepted in cycle N -> src_valid_o=1 in cycle N+1.
REQ-022 In SEND_S, src_valid_o SHALL be 1 and src_data_o SHALL be buffer[rd_cnt] (rd_cnt registered, starts at 0).
REQ-023 A beat SHALL be transferred when src_valid_o && src_ready_i; rd_cnt then increments.
REQ-024 While src_valid_o=1 and src_ready_i=0, src_data_o, src_startofpacket_o and src_endofpacket_o SHALL hold stable.
REQ-025 src_startofpacket_o SHALL be src_valid_o && rd_cnt==0; src_endofpacket_o SHALL be src_valid_o && rd_cnt==pkt_len_o-1.
REQ-026 A single-word packet SHALL assert SOP and EOP on the same beat.
REQ-027 A transfer with EOP SHALL return the FSM to FILL_S and clear wr_cnt and rd_cnt, so src_valid_o=0 and wr_ready_o=1 in the next cycle.
REQ-028 In FILL_S, src_valid_o, SOP and EOP SHALL be 0, and src_data_o SHALL be '0.
REQ-029 src_ready_i SHALL have no effect in FILL_S; wr_* inputs SHALL have no effect in SEND_S.

Reset
REQ-030 On srst_i=1: state=FILL_S; wr_cnt=0; rd_cnt=0; pkt_len_o=0; src_valid_o=0; SOP=0; EOP=0; src_data_o='0; overflow_o=0; wr_ready_o=1 from the cycle after reset.
REQ-031 Reset during SEND_S SHALL drop the packet: src_valid_o=0 in the next cycle, with no EOP emitted.
REQ-032 Buffer contents SHALL NOT require reset.

Structure
REQ-033 The state enum (FILL_S, SEND_S) SHALL live in shared package avalon_st_pkg.
REQ-034 Storage SHALL be one sub-module, pkt_buf: a MAX_PKT_LEN x DWIDTH register array with one synchronous write port and one asynchronous read port.

Verification
REQ-035 The bench SHALL cover: write 3,1,2 (last on 2), src_ready_i=1 -> beats 3,1,2 on consecutive cycles starting one cycle after the last write; SOP on 3; EOP on 2; pkt_len_o=3.
REQ-036 The bench SHALL cover: write single word 7 with last -> one beat, data 7, SOP=EOP=1, then wr_ready_o=1.
REQ-037 The bench SHALL cover: write 5 words 1..5 without last -> overflow_o pulses once, pkt_len_o=5, beats 1..5 with EOP on 5.
REQ-038 The bench SHALL cover: packet 4,9 with src_ready_i low for 3 cycles on each beat -> data and SOP/EOP stable while stalled, each beat transferred exactly once.
REQ-039 The bench SHALL cover: srst_i for 1 cycle after the first beat of a 4-word packet -> src_valid_o=0 next cycle, wr_ready_o=1, and a new packet 6,8 is sent correctly.
REQ-040 The bench SHALL cover: wr_valid_i held high during SEND_S with data 0xF -> ignored, and the next packet contains only words written after EOP.
